// File: rtl/spoc64_ctrl.sv
// spoc64_ctrl: SpoC-64 sequencer, steps the datapath through load, init, absorb, tag generate and tag verify.
module spoc64_ctrl #(
   parameter int PW        = 32,
   parameter int KEY_WORDS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   output logic       key_ready,
   input  logic       bdi_valid,
   output logic       bdi_ready,
   input  logic [3:0] bdi_type,
   input  logic [2:0] bdi_size,
   input  logic       bdi_eot,
   input  logic       decrypt,
   output logic       bdo_valid,
   input  logic       bdo_ready,
   output logic       auth_valid,
   output logic       dp_start,
   input  logic       dp_done,
   output logic       init_state,
   output logic       init_lock,
   output logic       en_state_in,
   output logic       lock_tag_state,
   output logic       en_key,
   output logic       en_npub,
   output logic       en_bdi,
   output logic       clr_bdi,
   output logic       half,
   output logic       sel_tag,
   output logic [1:0] ctrl_word,
   output logic       bdi_partial_reg,
   output logic       decrypt_reg
);
   localparam logic [3:0] WB = 4'(PW / 8);
   localparam logic [3:0] BB = 4'(PW / 4);
   localparam logic [1:0] WL = 2'(KEY_WORDS - 1);
   typedef enum logic [4:0] {
      IDLE, LD_KEY, LD_NPUB, INIT, INIT_W, LOCK, BLK, LDW, OUT_H, OUT_L,
      ABS, PERM_S, PERM_W, TAGL, TOUT_H, TOUT_L, TCLR, TIN, VER
   } state_t;
   state_t state, nxt;
   logic [1:0] wctr;
   logic [3:0] bytes, sum;
   logic half_q, last_msg, tag;
   logic key_fire, npub_fire, ldw_fire, tin_fire, is_msg, is_ad, empty, close;
   assign key_ready      = state == LD_KEY;
   assign bdi_ready      = state inside {LD_NPUB, LDW, TIN};
   assign bdo_valid      = state inside {OUT_H, OUT_L, TOUT_H, TOUT_L};
   assign auth_valid     = state == VER;
   assign dp_start       = state inside {INIT, PERM_S};
   assign init_state     = state inside {INIT, INIT_W};
   assign init_lock      = state == LOCK;
   assign en_state_in    = state inside {LOCK, ABS, TAGL};
   assign lock_tag_state = state == TAGL;
   assign sel_tag        = state inside {TOUT_H, TOUT_L};
   assign clr_bdi        = state inside {BLK, TCLR};
   assign key_fire       = key_ready & key_valid;
   assign npub_fire      = bdi_valid & (state == LD_NPUB);
   assign ldw_fire       = bdi_valid & (state == LDW);
   assign tin_fire       = bdi_valid & (state == TIN);
   assign en_key         = key_fire;
   assign en_npub        = npub_fire;
   assign en_bdi         = (state == BLK) | ldw_fire | tin_fire;
   assign half           = (state inside {OUT_L, TOUT_L}) | ((state inside {LDW, TIN}) & half_q);
   assign sum            = bytes + {1'b0, bdi_size};
   assign is_msg         = bdi_type == 4'b0100;
   assign is_ad          = bdi_type == 4'b0001;
   // an empty AD/MSG type arrives as a lone zero-size eot word
   assign empty          = !half_q & (bdi_size == 3'd0) & bdi_eot & (is_msg | is_ad);
   assign close          = ldw_fire & (half_q | bdi_eot) & !empty;
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = key_valid ? LD_KEY : IDLE;
         LD_KEY:  nxt = (key_fire && wctr == WL) ? LD_NPUB : LD_KEY;
         LD_NPUB: nxt = (npub_fire && wctr == WL) ? INIT : LD_NPUB;
         INIT:    nxt = INIT_W;
         INIT_W:  nxt = dp_done ? LOCK : INIT_W;
         LOCK:    nxt = BLK;
         BLK:     nxt = LDW;
         LDW:     nxt = (ldw_fire & empty) ? (is_msg ? TAGL : BLK) : close ? (is_msg ? OUT_H : ABS) : LDW;
         OUT_H:   nxt = bdo_ready ? ((bytes > WB) ? OUT_L : ABS) : OUT_H;
         OUT_L:   nxt = bdo_ready ? ABS : OUT_L;
         ABS:     nxt = PERM_S;
         PERM_S:  nxt = PERM_W;
         PERM_W:  nxt = !dp_done ? PERM_W : tag ? (decrypt_reg ? TCLR : TOUT_H) : last_msg ? TAGL : BLK;
         TAGL:    nxt = PERM_S;
         TOUT_H:  nxt = bdo_ready ? TOUT_L : TOUT_H;
         TOUT_L:  nxt = bdo_ready ? IDLE : TOUT_L;
         TCLR:    nxt = TIN;
         TIN:     nxt = (tin_fire & half_q) ? VER : TIN;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= IDLE;
         wctr            <= '0;
         bytes           <= '0;
         half_q          <= 1'b0;
         last_msg        <= 1'b0;
         tag             <= 1'b0;
         ctrl_word       <= '0;
         bdi_partial_reg <= 1'b0;
         decrypt_reg     <= 1'b0;
      end else begin
         state <= nxt;
         if (key_fire | npub_fire) wctr <= (wctr == WL) ? 2'd0 : wctr + 2'd1;
         if (npub_fire && wctr == 2'd0) decrypt_reg <= decrypt;
         if (state == BLK) begin
            bytes           <= '0;
            half_q          <= 1'b0;
            bdi_partial_reg <= 1'b0;
         end else if (state == TCLR) begin
            half_q <= 1'b0;
         end else if (ldw_fire | tin_fire) begin
            bytes  <= sum;
            half_q <= !half_q;
         end
         if (close) begin
            bdi_partial_reg <= sum < BB;
            ctrl_word       <= is_ad ? 2'b01 : is_msg ? 2'b10 : 2'b00;
            last_msg        <= is_msg & bdi_eot;
         end
         if (state == TAGL) tag <= 1'b1;
         if (state == IDLE) begin
            tag       <= 1'b0;
            last_msg  <= 1'b0;
            ctrl_word <= '0;
         end
      end
   end
endmodule

// File: tb/tb_spoc64_ctrl.sv
// tb_spoc64_ctrl: directed scenarios for the SpoC-64 sequencer with a fixed-latency permutation model.
module tb_spoc64_ctrl;
   logic clk = 0, rst = 0;
   logic key_valid = 0, bdi_valid = 0, bdi_eot = 0, decrypt = 0, bdo_ready = 0, dp_done;
   logic [3:0] bdi_type = 0;
   logic [2:0] bdi_size = 0;
   logic key_ready, bdi_ready, bdo_valid, auth_valid, dp_start, init_state, init_lock, en_state_in;
   logic lock_tag_state, en_key, en_npub, en_bdi, clr_bdi, half, sel_tag, bdi_partial_reg, decrypt_reg;
   logic [1:0] ctrl_word;
   logic [18:0] allout;
   int errors = 0, checks = 0, n_start = 0, n_bdo = 0, n_auth = 0, dp_cnt, dp_lat = 3;

   spoc64_ctrl dut (
      .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready),
      .bdi_valid(bdi_valid), .bdi_ready(bdi_ready), .bdi_type(bdi_type), .bdi_size(bdi_size),
      .bdi_eot(bdi_eot), .decrypt(decrypt), .bdo_valid(bdo_valid), .bdo_ready(bdo_ready),
      .auth_valid(auth_valid), .dp_start(dp_start), .dp_done(dp_done), .init_state(init_state),
      .init_lock(init_lock), .en_state_in(en_state_in), .lock_tag_state(lock_tag_state),
      .en_key(en_key), .en_npub(en_npub), .en_bdi(en_bdi), .clr_bdi(clr_bdi), .half(half),
      .sel_tag(sel_tag), .ctrl_word(ctrl_word), .bdi_partial_reg(bdi_partial_reg),
      .decrypt_reg(decrypt_reg)
   );

   always #5 clk = ~clk;

   assign allout = {key_ready, bdi_ready, bdo_valid, auth_valid, dp_start, init_state, init_lock,
                    en_state_in, lock_tag_state, en_key, en_npub, en_bdi, clr_bdi, half, sel_tag,
                    ctrl_word, bdi_partial_reg, decrypt_reg};

   // permutation model: dp_done pulses dp_lat cycles after dp_start
   always @(posedge clk or negedge rst)
      if (!rst) begin
         dp_cnt  <= 0;
         dp_done <= 1'b0;
      end else begin
         dp_done <= 1'b0;
         if (dp_start) dp_cnt <= dp_lat;
         else if (dp_cnt != 0) begin
            dp_cnt <= dp_cnt - 1;
            if (dp_cnt == 1) dp_done <= 1'b1;
         end
      end

   always @(posedge clk) begin
      if (dp_start) n_start <= n_start + 1;
      if (bdo_valid && bdo_ready) n_bdo <= n_bdo + 1;
      if (auth_valid) n_auth <= n_auth + 1;
   end

   task automatic word(input logic [3:0] ty, input logic [2:0] sz, input logic e);
      int t = 0;
      bdi_type = ty; bdi_size = sz; bdi_eot = e; bdi_valid = 1;
      while (!bdi_ready && t < 200) begin @(negedge clk); t++; end
      checks++;
      if (!bdi_ready) begin errors++; $display("FAIL bdi_wait type=%b: ready got 0 want 1", ty); end
      @(negedge clk);
      bdi_valid = 0; bdi_eot = 0;
   endtask

   task automatic take_bdo(output logic h, output logic s);
      int t = 0;
      while (!bdo_valid && t < 200) begin @(negedge clk); t++; end
      checks++;
      if (!bdo_valid) begin errors++; $display("FAIL bdo_wait: valid got 0 want 1"); end
      h = half; s = sel_tag;
      bdo_ready = 1;
      @(negedge clk);
      bdo_ready = 0;
   endtask

   task automatic front(input logic dec);
      int c = 0, t = 0;
      key_valid = 1;
      while (c < 4 && t < 100) begin
         if (key_ready) c++;
         @(negedge clk);
         t++;
      end
      key_valid = 0;
      checks++;
      if (c != 4) begin errors++; $display("FAIL key_load: fires got %0d want 4", c); end
      decrypt = dec;
      word(4'b1101, 4, 0);
      decrypt = !dec;
      word(4'b1101, 4, 0);
      word(4'b1101, 4, 0);
      word(4'b1101, 4, 1);
   endtask

   task automatic test_reset;
      key_valid = 1;
      repeat (3) @(negedge clk);
      checks++;
      if (allout !== 19'd0) begin errors++; $display("FAIL reset_outs: got %h want 0", allout); end
      key_valid = 0;
      rst = 1;
      @(negedge clk);
      checks++;
      if (allout !== 19'd0) begin errors++; $display("FAIL idle_outs: got %h want 0", allout); end
   endtask

   task automatic test_enc;
      int s0 = n_start, b0 = n_bdo;
      logic h, s;
      front(0);
      checks++;
      if (decrypt_reg !== 1'b0) begin errors++; $display("FAIL enc_dir: got %b want 0", decrypt_reg); end
      word(4'b0001, 4, 0);
      word(4'b0001, 4, 1);
      checks++;
      if (ctrl_word !== 2'b01) begin errors++; $display("FAIL enc_ctrl_ad: got %b want 01", ctrl_word); end
      word(4'b0100, 4, 0);
      word(4'b0100, 4, 1);
      checks++;
      if ({ctrl_word, bdi_partial_reg, bdo_valid} !== 4'b1001)
         begin errors++; $display("FAIL enc_ctrl_msg: got %b want 1001", {ctrl_word, bdi_partial_reg, bdo_valid}); end
      take_bdo(h, s);
      checks++;
      if ({h, s} !== 2'b00) begin errors++; $display("FAIL enc_ct0: half/sel got %b want 00", {h, s}); end
      take_bdo(h, s);
      checks++;
      if ({h, s} !== 2'b10) begin errors++; $display("FAIL enc_ct1: half/sel got %b want 10", {h, s}); end
      take_bdo(h, s);
      checks++;
      if ({h, s} !== 2'b01) begin errors++; $display("FAIL enc_tag0: half/sel got %b want 01", {h, s}); end
      take_bdo(h, s);
      checks++;
      if ({h, s} !== 2'b11) begin errors++; $display("FAIL enc_tag1: half/sel got %b want 11", {h, s}); end
      @(negedge clk);
      checks++;
      if (n_start - s0 !== 4) begin errors++; $display("FAIL enc_starts: got %0d want 4", n_start - s0); end
      checks++;
      if (n_bdo - b0 !== 4) begin errors++; $display("FAIL enc_bdo: got %0d want 4", n_bdo - b0); end
      checks++;
      if (allout !== 19'd0) begin errors++; $display("FAIL enc_idle: got %h want 0", allout); end
   endtask

   task automatic test_partial;
      int b0 = n_bdo;
      logic h, s;
      front(0);
      word(4'b0001, 0, 1);
      word(4'b0100, 3, 1);
      checks++;
      if ({bdi_partial_reg, bdo_valid, half} !== 3'b110)
         begin errors++; $display("FAIL part_outh: got %b want 110", {bdi_partial_reg, bdo_valid, half}); end
      take_bdo(h, s);
      checks++;
      if ({bdo_valid, en_state_in} !== 2'b01)
         begin errors++; $display("FAIL part_skip_outl: valid/en_state got %b want 01", {bdo_valid, en_state_in}); end
      take_bdo(h, s);
      checks++;
      if ({h, s} !== 2'b01) begin errors++; $display("FAIL part_tag0: got %b want 01", {h, s}); end
      take_bdo(h, s);
      checks++;
      if (n_bdo - b0 !== 3) begin errors++; $display("FAIL part_bdo: got %0d want 3", n_bdo - b0); end
   endtask

   task automatic test_dec;
      int s0 = n_start, b0 = n_bdo, a0 = n_auth;
      logic h, s;
      front(1);
      checks++;
      if (decrypt_reg !== 1'b1) begin errors++; $display("FAIL dec_dir: got %b want 1", decrypt_reg); end
      word(4'b0001, 0, 1);
      word(4'b0100, 4, 0);
      word(4'b0100, 4, 0);
      checks++;
      if (bdi_partial_reg !== 1'b0) begin errors++; $display("FAIL dec_full: got %b want 0", bdi_partial_reg); end
      take_bdo(h, s);
      take_bdo(h, s);
      checks++;
      if (h !== 1'b1) begin errors++; $display("FAIL dec_low_half: got %b want 1", h); end
      word(4'b0100, 4, 1);
      checks++;
      if (bdi_partial_reg !== 1'b1) begin errors++; $display("FAIL dec_part: got %b want 1", bdi_partial_reg); end
      take_bdo(h, s);
      checks++;
      if (bdo_valid !== 1'b0) begin errors++; $display("FAIL dec_no_outl: got %b want 0", bdo_valid); end
      word(4'b0101, 4, 0);
      checks++;
      if (auth_valid !== 1'b0) begin errors++; $display("FAIL dec_auth_early: got %b want 0", auth_valid); end
      word(4'b0101, 4, 1);
      checks++;
      if (auth_valid !== 1'b1) begin errors++; $display("FAIL dec_auth: got %b want 1", auth_valid); end
      @(negedge clk);
      checks++;
      if (auth_valid !== 1'b0) begin errors++; $display("FAIL dec_auth_pulse: got %b want 0", auth_valid); end
      checks++;
      if (n_auth - a0 !== 1) begin errors++; $display("FAIL dec_auth_cnt: got %0d want 1", n_auth - a0); end
      checks++;
      if (n_start - s0 !== 4) begin errors++; $display("FAIL dec_starts: got %0d want 4", n_start - s0); end
      checks++;
      if (n_bdo - b0 !== 3) begin errors++; $display("FAIL dec_bdo: got %0d want 3", n_bdo - b0); end
   endtask

   task automatic test_stall;
      logic h, s;
      front(0);
      word(4'b0001, 0, 1);
      word(4'b0100, 4, 0);
      word(4'b0100, 4, 1);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({bdo_valid, half, en_state_in} !== 3'b100)
            begin errors++; $display("FAIL stall_%0d: valid/half/en_state got %b want 100", i, {bdo_valid, half, en_state_in}); end
         @(negedge clk);
      end
      take_bdo(h, s);
      checks++;
      if ({h, s} !== 2'b00) begin errors++; $display("FAIL stall_ct0: got %b want 00", {h, s}); end
      take_bdo(h, s);
      take_bdo(h, s);
      take_bdo(h, s);
      checks++;
      if ({h, s} !== 2'b11) begin errors++; $display("FAIL stall_tag1: got %b want 11", {h, s}); end
   endtask

   task automatic test_reset_mid;
      int s0, b0;
      logic h, s;
      dp_lat = 20;
      front(0);
      word(4'b0001, 4, 1);
      repeat (3) @(negedge clk);
      rst = 0;
      #1;
      checks++;
      if (allout !== 19'd0) begin errors++; $display("FAIL rmid_async: got %h want 0", allout); end
      @(negedge clk);
      checks++;
      if (allout !== 19'd0) begin errors++; $display("FAIL rmid_edge: got %h want 0", allout); end
      rst = 1;
      dp_lat = 3;
      @(negedge clk);
      s0 = n_start; b0 = n_bdo;
      front(0);
      word(4'b0001, 4, 1);
      word(4'b0100, 4, 1);
      checks++;
      if ({ctrl_word, bdi_partial_reg} !== 3'b101)
         begin errors++; $display("FAIL rmid_ctrl: got %b want 101", {ctrl_word, bdi_partial_reg}); end
      take_bdo(h, s);
      take_bdo(h, s);
      take_bdo(h, s);
      checks++;
      if ({h, s} !== 2'b11) begin errors++; $display("FAIL rmid_tag1: got %b want 11", {h, s}); end
      @(negedge clk);
      checks++;
      if (n_start - s0 !== 4) begin errors++; $display("FAIL rmid_starts: got %0d want 4", n_start - s0); end
      checks++;
      if (n_bdo - b0 !== 3) begin errors++; $display("FAIL rmid_bdo: got %0d want 3", n_bdo - b0); end
   endtask

   initial begin
      @(negedge clk);
      test_reset;
      test_enc;
      test_partial;
      test_dec;
      test_stall;
      test_reset_mid;
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
